hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core types for the pipeline hazard controller: FSM states, forward selects
// and the register-dependency match helper.
package coreUtils;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    // x0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rs, input logic src_used,
                                       input logic [4:0] rd, input logic wreg);
        return src_used && wreg && (rd != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             inc,
    output logic [width-1:0] value
);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + width'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory freeze/timeout FSM, redirects, data stalls.
// Build option HAZARD_FORWARD_EN enables MEM/WB operand forwarding (only load-use stalls).
module hazard_ctrl
    import coreUtils::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_Wreg,
    input  logic             ex_isLoad,
    input  logic [4:0]       mem_rd,
    input  logic             mem_Wreg,
    input  logic [4:0]       wb_rd,
    input  logic             wb_Wreg,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t     state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg;

    logic [4:0] src_rs   [2];
    logic       src_used [2];
    logic [1:0] ex_hit, mem_hit, wb_hit;
    logic       data_stall, frozen, stall_inc, flush_inc;
    fwd_sel_t   fwd_raw_a, fwd_raw_b;

    assign src_rs[0]   = id_rs1;
    assign src_rs[1]   = id_rs2;
    assign src_used[0] = id_use1;
    assign src_used[1] = id_use2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi]  = reg_match(src_rs[gi], src_used[gi], ex_rd,  ex_Wreg);
            assign mem_hit[gi] = reg_match(src_rs[gi], src_used[gi], mem_rd, mem_Wreg);
            assign wb_hit[gi]  = reg_match(src_rs[gi], src_used[gi], wb_rd,  wb_Wreg);
        end
    endgenerate

`ifdef HAZARD_FORWARD_EN
    // MEM holds the younger value, so it wins over WB.
    assign fwd_raw_a  = mem_hit[0] ? FWD_MEM : (wb_hit[0] ? FWD_WB : FWD_NONE);
    assign fwd_raw_b  = mem_hit[1] ? FWD_MEM : (wb_hit[1] ? FWD_WB : FWD_NONE);
    assign data_stall = ex_isLoad && (|ex_hit);
`else
    logic unused_load;
    assign unused_load = ex_isLoad;
    assign fwd_raw_a   = FWD_NONE;
    assign fwd_raw_b   = FWD_NONE;
    assign data_stall  = |{ex_hit, mem_hit, wb_hit};
`endif

    // The cycle dmem_ready arrives the access completes, so the pipeline may advance.
    assign frozen = !dmem_ready && ((state_reg == MEM_WAIT) ||
                                    ((state_reg == RUN) && dmem_req));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        fwd_a         = FWD_NONE;
        fwd_b         = FWD_NONE;

        case (state_reg)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_next = ERR;
                    end
                end
            end
            default: state_next = ERR;
        endcase

        if (nReset) begin
            fwd_a = fwd_raw_a;
            fwd_b = fwd_raw_b;
            if ((state_reg == ERR) || frozen) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (data_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_reg | (state_next == ERR);
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_inc = (state_reg != ERR) && !pc_en;
    assign flush_inc = (state_reg != ERR) && !frozen && ex_redirect;

    sat_counter #(.width(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .nReset (nReset),
        .inc    (stall_inc),
        .value  (stall_cnt)
    );

    sat_counter #(.width(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .nReset (nReset),
        .inc    (flush_inc),
        .value  (flush_cnt)
    );

endmodule
